// File: rtl/mux2to1.sv
// mux2to1: 2:1 selection primitive built three ways (conditional operator,
// if/else, case). A registered copy of the conditional-operator path and a
// cross-check monitor sit alongside. The monitor flags any cycle in which the
// three combinational paths disagree and keeps a saturating count of such
// cycles. All registers use a synchronous, active-high reset.
module mux2to1 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out_q,
    output logic             mismatch,
    output logic [CNT_W-1:0] mismatch_cnt
);

    logic [WIDTH-1:0] out_q_r;
    logic [WIDTH-1:0] out_d;
    logic             mismatch_q;
    logic             mismatch_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             diff;
    logic             cnt_full;

    // Path 1: conditional operator.
    always_comb begin
        out1 = sel ? in1 : in0;
    end

    // Path 2: if/else.
    always_comb begin
        if (sel) begin
            out2 = in1;
        end else begin
            out2 = in0;
        end
    end

    // Path 3: case; default falls back to in0 so the decode is always complete.
    always_comb begin
        case (sel)
            1'b0:    out3 = in0;
            1'b1:    out3 = in1;
            default: out3 = in0;
        endcase
    end

    // Cross-check: any bit differing between path 1 and either other path.
    always_comb begin
        diff     = (out1 != out2) || (out1 != out3);
        cnt_full = &cnt_q;
    end

    // Next-state values for the registered copy, the flag and the counter.
    always_comb begin
        out_d      = out1;
        mismatch_d = diff;
        cnt_d      = cnt_q;
        if (diff && !cnt_full) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Registers; reset overrides any disagreement seen in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q_r    <= '0;
            mismatch_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            out_q_r    <= out_d;
            mismatch_q <= mismatch_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_q        = out_q_r;
    assign mismatch     = mismatch_q;
    assign mismatch_cnt = cnt_q;

endmodule

// File: tb/tb_mux2to1.sv
// Testbench for mux2to1: one WIDTH=1 and one WIDTH=4 instance sharing clock,
// reset and select, checked against a truth-table reference model.
module tb_mux2to1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic [0:0] a0 = '0, a1 = '0;
    logic [3:0] b0 = '0, b1 = '0;

    logic [0:0] a_o1, a_o2, a_o3, a_oq;
    logic [3:0] b_o1, b_o2, b_o3, b_oq;
    logic       a_mm, b_mm;
    logic [7:0] a_cnt, b_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Truth table indexed by {sel,in0,in1}: 000..111 -> 0,0,1,1,0,1,0,1
    logic [7:0] tt = 8'b1010_1100;

    logic [0:0] exp_aq = '0;
    logic [3:0] exp_bq = '0;

    mux2to1 #(.WIDTH(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .in0(a0), .in1(a1), .sel(sel),
        .out1(a_o1), .out2(a_o2), .out3(a_o3), .out_q(a_oq),
        .mismatch(a_mm), .mismatch_cnt(a_cnt)
    );

    mux2to1 #(.WIDTH(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst(rst), .in0(b0), .in1(b1), .sel(sel),
        .out1(b_o1), .out2(b_o2), .out3(b_o3), .out_q(b_oq),
        .mismatch(b_mm), .mismatch_cnt(b_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ref_mux(input logic s, input logic [3:0] x0,
                                           input logic [3:0] x1, input int w);
        logic [3:0] r;
        r = '0;
        for (int b = 0; b < w; b++) r[b] = tt[{s, x0[b], x1[b]}];
        return r;
    endfunction

    // Reference registers: load the model output each edge, clear under reset.
    always @(posedge clk) begin
        if (rst) begin
            exp_aq = '0;
            exp_bq = '0;
        end else begin
            exp_aq = ref_mux(sel, {3'b0, a0}, {3'b0, a1}, 1);
            exp_bq = ref_mux(sel, b0, b1, 4);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_comb();
        logic [3:0] ea, eb;
        ea = ref_mux(sel, {3'b0, a0}, {3'b0, a1}, 1);
        eb = ref_mux(sel, b0, b1, 4);
        chk("w1_out1", {31'b0, a_o1}, {28'b0, ea});
        chk("w1_out2", {31'b0, a_o2}, {28'b0, ea});
        chk("w1_out3", {31'b0, a_o3}, {28'b0, ea});
        chk("w4_out1", {28'b0, b_o1}, {28'b0, eb});
        chk("w4_out2", {28'b0, b_o2}, {28'b0, eb});
        chk("w4_out3", {28'b0, b_o3}, {28'b0, eb});
    endtask

    task automatic chk_regs();
        chk("w1_out_q", {31'b0, a_oq}, {31'b0, exp_aq});
        chk("w4_out_q", {28'b0, b_oq}, {28'b0, exp_bq});
        chk("w1_mismatch", {31'b0, a_mm}, 32'd0);
        chk("w4_mismatch", {31'b0, b_mm}, 32'd0);
        chk("w1_mm_cnt", {24'b0, a_cnt}, 32'd0);
        chk("w4_mm_cnt", {24'b0, b_cnt}, 32'd0);
    endtask

    initial begin
        logic [2:0] v;
        logic [0:0] exp_sweep;
        logic [7:0] sweep_exp;
        sweep_exp = 8'b1010_1100;

        repeat (2) @(posedge clk);

        // Exhaustive sweep under reset: combinational paths valid, registers held at 0.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            v   = 3'(i);
            sel = v[2];
            a0  = v[1];
            a1  = v[0];
            b0  = {4{v[1]}};
            b1  = {4{v[0]}};
            #1;
            exp_sweep = sweep_exp[i];
            chk("sweep_out1", {31'b0, a_o1}, {31'b0, exp_sweep});
            chk_comb();
            #39;
            chk("sweep_rst_q", {31'b0, a_oq}, 32'd0);
            #10;
        end

        // Reset held two edges with out1=1, then release.
        @(negedge clk);
        rst = 1'b1; sel = 1'b0; a0 = 1'b1; a1 = 1'b0; b0 = 4'hA; b1 = 4'h5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_q", {31'b0, a_oq}, 32'd0);
        chk_regs();
        rst = 1'b0;
        @(negedge clk);
        chk("rel_out_q", {31'b0, a_oq}, 32'd1);
        chk("rel_w4_q", {28'b0, b_oq}, 32'hA);
        chk_regs();

        // Latency: toggling sel changes out1 at once, out_q only after the edge.
        sel = 1'b1;
        #1;
        chk("lat_out1", {31'b0, a_o1}, 32'd0);
        chk("lat_w4_out1", {28'b0, b_o1}, 32'h5);
        chk("lat_q_hold", {31'b0, a_oq}, 32'd1);
        chk("lat_w4_hold", {28'b0, b_oq}, 32'hA);
        chk_comb();
        @(negedge clk);
        chk("lat_q_new", {31'b0, a_oq}, 32'd0);
        chk("lat_w4_new", {28'b0, b_oq}, 32'h5);
        chk_regs();

        // Random traffic with a one-edge reset pulse in the middle.
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            chk_regs();
            if (c == 501) begin
                chk("midrst_w1_q", {31'b0, a_oq}, 32'd0);
                chk("midrst_w4_q", {28'b0, b_oq}, 32'd0);
            end
            rst = (c == 500);
            sel = 1'($urandom_range(0, 1));
            a0  = 1'($urandom_range(0, 1));
            a1  = 1'($urandom_range(0, 1));
            b0  = 4'($urandom_range(0, 15));
            b1  = 4'($urandom_range(0, 15));
            #1;
            chk_comb();
        end
        @(negedge clk);
        rst = 1'b0;
        chk_regs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
